// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU command sequencer: FSM states,
// ALU control bit positions and the named opcodes used by software.
package alu_sequencer_pkg;

    // Sequencer states: waiting for a command, one ALU cycle, result held.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } seq_state_t;

    // Bit positions of the ALU controls inside a 6-bit opcode.
    localparam int ZX = 5;
    localparam int NX = 4;
    localparam int ZY = 3;
    localparam int NY = 2;
    localparam int F  = 1;
    localparam int NO = 0;

    // Named opcodes {zx,nx,zy,ny,f,no}.
    localparam logic [5:0] OP_ZERO = 6'b101010;
    localparam logic [5:0] OP_NEG1 = 6'b111010;
    localparam logic [5:0] OP_ADD  = 6'b000010;
    localparam logic [5:0] OP_SUB  = 6'b010011;
    localparam logic [5:0] OP_AND  = 6'b000000;

endpackage

// File: rtl/alu_sequencer_regfile.sv
// Small register file for the sequencer: two asynchronous read ports,
// one synchronous write port, whole array cleared on reset.
module alu_regfile
    import alu_sequencer_pkg::*;
#(
    parameter  int WIDTH = 4,
    parameter  int NREGS = 4,
    localparam int RAW   = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_we,
    input  logic [RAW-1:0]   i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [RAW-1:0]   i_raddr_x,
    input  logic [RAW-1:0]   i_raddr_y,
    output logic [WIDTH-1:0] o_rdata_x,
    output logic [WIDTH-1:0] o_rdata_y
);

    logic [WIDTH-1:0] r_mem [NREGS];

    // Storage: reset clears every entry and wins over a pending write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_x = r_mem[i_raddr_x];
    assign o_rdata_y = r_mem[i_raddr_y];

endmodule

// File: rtl/alu_sequencer.sv
// Command front-end around an external 4-bit combinational ALU.
// Accepts one command at a time, reads operands from the register file,
// drives the ALU from latched state, writes the result back and offers it
// with zero/negative flags on a valid/ready result channel.
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter  int WIDTH = 4,
    parameter  int NREGS = 4,
    localparam int RAW   = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    // command channel
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_ld,
    input  logic [5:0]       cmd_op,
    input  logic [RAW-1:0]   cmd_srcx,
    input  logic [RAW-1:0]   cmd_srcy,
    input  logic [RAW-1:0]   cmd_dst,
    input  logic             cmd_wen,
    input  logic [WIDTH-1:0] cmd_imm,
    // external ALU
    output logic             alu_zx,
    output logic             alu_nx,
    output logic             alu_zy,
    output logic             alu_ny,
    output logic             alu_f,
    output logic             alu_no,
    output logic [WIDTH-1:0] alu_x,
    output logic [WIDTH-1:0] alu_y,
    input  logic [WIDTH-1:0] alu_r,
    // result channel
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_zr,
    output logic             res_ng
);

    seq_state_t       r_state;
    logic [5:0]       r_op;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] r_res;
    logic [RAW-1:0]   r_dst;
    logic             r_wen;

    logic             w_accept;
    logic             w_we;
    logic [RAW-1:0]   w_waddr;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_rd_x;
    logic [WIDTH-1:0] w_rd_y;

    assign w_accept = (r_state == IDLE) && cmd_valid;

    alu_regfile #(
        .WIDTH (WIDTH),
        .NREGS (NREGS)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .i_we      (w_we),
        .i_waddr   (w_waddr),
        .i_wdata   (w_wdata),
        .i_raddr_x (cmd_srcx),
        .i_raddr_y (cmd_srcy),
        .o_rdata_x (w_rd_x),
        .o_rdata_y (w_rd_y)
    );

    // Writeback select: immediates go in at accept, ALU results at the end of EXEC.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_dst;
        w_wdata = alu_r;
        if (w_accept && cmd_ld) begin
            w_we    = cmd_wen;
            w_waddr = cmd_dst;
            w_wdata = cmd_imm;
        end else if (r_state == EXEC) begin
            w_we    = r_wen;
        end
    end

    // Sequencer FSM with all latched command state and the held result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_op    <= OP_AND;
            r_x     <= '0;
            r_y     <= '0;
            r_res   <= '0;
            r_dst   <= '0;
            r_wen   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        r_op  <= cmd_op;
                        r_dst <= cmd_dst;
                        r_wen <= cmd_wen;
                        r_x   <= w_rd_x;
                        r_y   <= w_rd_y;
                        if (cmd_ld) begin
                            r_res   <= cmd_imm;
                            r_state <= RESP;
                        end else begin
                            r_state <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    r_res   <= alu_r;
                    r_state <= RESP;
                end
                RESP: begin
                    if (res_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = (r_state == IDLE);
    assign res_valid = (r_state == RESP);

    // The ALU only ever sees latched state, never the live command bus.
    assign alu_zx = r_op[ZX];
    assign alu_nx = r_op[NX];
    assign alu_zy = r_op[ZY];
    assign alu_ny = r_op[NY];
    assign alu_f  = r_op[F];
    assign alu_no = r_op[NO];
    assign alu_x  = r_x;
    assign alu_y  = r_y;

    assign res_data = r_res;
    assign res_zr   = (r_res == '0);
    assign res_ng   = r_res[WIDTH-1];

endmodule
